// File: rtl/branch_predictor_pkg.sv
// branch_predictor_pkg: shared word type, BTB counter states, entry layout and counter update
package cpu_types_pkg;
  typedef logic [31:0] word_t;
endpackage

package datapath_types_pkg;
  import cpu_types_pkg::*;
  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } bp_cnt_t;
  // tag is kept at full pc[31:2] width so any ENTRIES fits; unused upper bits stay zero
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    word_t       target;
    bp_cnt_t     cnt;
  } btb_entry_t;
  function automatic bp_cnt_t sat_update(bp_cnt_t c, logic taken);
    return taken ? ((c == STRONG_T) ? c : bp_cnt_t'(c + 2'd1))
                 : ((c == STRONG_NT) ? c : bp_cnt_t'(c - 2'd1));
  endfunction
endpackage

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit saturating counters and a mispredict counter
module branch_predictor
  import cpu_types_pkg::*, datapath_types_pkg::*;
#(
  parameter int ENTRIES = 16,
  localparam int IDX_W = $clog2(ENTRIES),
  parameter bp_cnt_t CNT_INIT = WEAK_NT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        lookup_en,
  input  logic [31:0] lookup_pc,
  output logic        pred_control,
  output logic [31:0] pred_branch,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispredict,
  output logic [31:0] mispred_cnt
);
  btb_entry_t btb [ENTRIES];
  logic [IDX_W-1:0] l_idx, u_idx;
  logic [29:0] l_tag, u_tag;
  logic l_hit, u_hit;
  assign l_idx = lookup_pc[IDX_W+1:2];
  assign u_idx = upd_pc[IDX_W+1:2];
  assign l_tag = 30'(lookup_pc >> (IDX_W + 2));
  assign u_tag = 30'(upd_pc >> (IDX_W + 2));
  assign l_hit = lookup_en && btb[l_idx].valid && btb[l_idx].tag == l_tag;
  assign u_hit = btb[u_idx].valid && btb[u_idx].tag == u_tag;
  assign pred_control = l_hit && btb[l_idx].cnt[1];
  assign pred_branch = pred_control ? btb[l_idx].target : lookup_pc + 32'd4;
  // array reads above see pre-update state: a same-cycle update shows up next cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++)
        btb[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: CNT_INIT};
      mispred_cnt <= '0;
    end else if (upd_valid) begin
      if (u_hit) begin
        btb[u_idx].cnt <= sat_update(btb[u_idx].cnt, upd_taken);
        if (upd_taken) btb[u_idx].target <= upd_target;
      end else if (upd_taken)
        btb[u_idx] <= '{valid: 1'b1, tag: u_tag, target: upd_target, cnt: WEAK_T};
      if (upd_mispredict && mispred_cnt != '1) mispred_cnt <= mispred_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed checks of lookup, training, aliasing, reset and mispredict counting
module tb_branch_predictor;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        lookup_en = 1'b0;
  logic [31:0] lookup_pc = '0;
  logic        pred_control;
  logic [31:0] pred_branch;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_mispredict = 1'b0;
  logic [31:0] mispred_cnt;
  int total = 0;
  int bad = 0;

  branch_predictor dut (
    .CLK(CLK), .RST(RST), .lookup_en(lookup_en), .lookup_pc(lookup_pc),
    .pred_control(pred_control), .pred_branch(pred_branch),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict), .mispred_cnt(mispred_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic look(input logic [31:0] pc, input string tag, input logic pc_exp, input logic [31:0] br_exp);
    lookup_pc = pc;
    #1;
    chk({tag, "_ctl"}, {31'd0, pred_control}, {31'd0, pc_exp});
    chk({tag, "_br"}, pred_branch, br_exp);
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt, input logic mis);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = taken; upd_target = tgt; upd_mispredict = mis;
    tick();
    upd_valid = 1'b0; upd_mispredict = 1'b0;
  endtask

  initial begin
    tick();
    RST = 1'b0;
    lookup_en = 1'b1;
    look(32'h40, "reset_lookup", 1'b0, 32'h44);
    chk("reset_mispred", mispred_cnt, 32'd0);
    // first taken update with simultaneous lookup: old contents seen this cycle
    upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h100;
    look(32'h40, "same_cycle", 1'b0, 32'h44);
    tick();
    upd_valid = 1'b0;
    look(32'h40, "after_alloc", 1'b1, 32'h100);
    upd(32'h40, 1'b1, 32'h100, 1'b0);
    upd(32'h40, 1'b1, 32'h100, 1'b0);
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    look(32'h40, "strong_to_weak", 1'b1, 32'h100);
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    look(32'h40, "weak_nt", 1'b0, 32'h44);
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    upd(32'h40, 1'b1, 32'h140, 1'b0);
    look(32'h40, "sat_low_recover", 1'b0, 32'h44);
    upd(32'h40, 1'b1, 32'h150, 1'b0);
    look(32'h40, "retrain_target", 1'b1, 32'h150);
    look(32'h80, "alias_miss", 1'b0, 32'h84);
    upd(32'h80, 1'b1, 32'h200, 1'b0);
    look(32'h80, "alias_alloc", 1'b1, 32'h200);
    look(32'h40, "alias_evicted", 1'b0, 32'h44);
    lookup_en = 1'b0;
    look(32'h80, "lookup_disabled", 1'b0, 32'h84);
    lookup_en = 1'b1;
    look(32'hFFFF_FFFC, "pc_wrap", 1'b0, 32'h0);
    upd(32'h304, 1'b0, 32'h900, 1'b0);
    look(32'h304, "no_alloc_nt", 1'b0, 32'h308);
    upd(32'h500, 1'b0, 32'h0, 1'b1);
    upd(32'h500, 1'b0, 32'h0, 1'b1);
    upd(32'h500, 1'b0, 32'h0, 1'b1);
    chk("mispred_three", mispred_cnt, 32'd3);
    upd_mispredict = 1'b1;
    tick();
    upd_mispredict = 1'b0;
    chk("mispred_needs_valid", mispred_cnt, 32'd3);
    // reset together with an update: the update must be dropped
    RST = 1'b1;
    upd(32'h80, 1'b1, 32'h200, 1'b1);
    RST = 1'b0;
    chk("rst_mispred", mispred_cnt, 32'd0);
    look(32'h80, "rst_miss_80", 1'b0, 32'h84);
    look(32'h40, "rst_miss_40", 1'b0, 32'h44);
    upd(32'h80, 1'b1, 32'h220, 1'b0);
    look(32'h80, "post_rst_alloc", 1'b1, 32'h220);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
